pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It generates the per-stage stall and clear strobes that the datapath consumes. It detects load-use hazards, flushes younger stages on taken branches and jumps, and holds the pipeline while a variable-latency data memory is busy. It also sequences a post-reset flush and a memory-timeout error lockout.

---
 rtl/pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use, branch/jump flush, memory wait, reset flush, timeout lockout.
// Optional performance counters are compiled in with `define PIPE_HAZ_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rd_addr_a,
  input  logic [4:0]       id_rd_addr_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_jump,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_branch,
  input  logic             mem_rd_req,
  input  logic             mem_wr_req,
  input  logic             mem_ready,
`ifdef PIPE_HAZ_PERF_EN
  output logic [CNT_W-1:0] perf_load_stall,
  output logic [CNT_W-1:0] perf_mem_stall,
  output logic [CNT_W-1:0] perf_flush,
`endif
  output logic             pc_stall,
  output logic             if_stall,
  output logic             if_clear,
  output logic             id_stall,
  output logic             id_clear,
  output logic             ex_stall,
  output logic             ex_clear,
  output logic             mem_stall,
  output logic             mem_clear,
  output logic             mem_err
);

  // Wide enough to reach MEM_TIMEOUT and still have headroom to saturate.
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [3:0]        FLUSH_LAST = 4'(RST_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = {WAIT_W{1'b1}};

  typedef enum logic [1:0] {
    S_FLUSH    = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        flush_cnt, flush_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_busy;
  logic              load_use;

  assign mem_busy = (mem_rd_req | mem_wr_req) & ~mem_ready;
  assign load_use = ex_mem_rd & (ex_wr_addr != 5'd0) &
                    ((id_use_a & (id_rd_addr_a == ex_wr_addr)) |
                     (id_use_b & (id_rd_addr_b == ex_wr_addr)));

  // State, flush counter and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FLUSH;
      flush_cnt <= 4'd0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  // Next-state logic and combinational stall/clear strobes.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    if_clear  = 1'b0;
    id_stall  = 1'b0;
    id_clear  = 1'b0;
    ex_stall  = 1'b0;
    ex_clear  = 1'b0;
    mem_stall = 1'b0;
    mem_clear = 1'b0;
    mem_err   = 1'b0;
    case (state)
      S_FLUSH: begin
        pc_stall  = 1'b1;
        if_clear  = 1'b1;
        id_clear  = 1'b1;
        ex_clear  = 1'b1;
        mem_clear = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt     = S_RUN;
          flush_cnt_nxt = 4'd0;
        end else begin
          flush_cnt_nxt = flush_cnt + 4'd1;
        end
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_clear = 1'b1;
        end else if (ex_branch) begin
          if_clear = 1'b1;
          id_clear = 1'b1;
        end else if (load_use) begin
          pc_stall = 1'b1;
          if_stall = 1'b1;
          id_clear = 1'b1;
        end else if (id_jump) begin
          if_clear = 1'b1;
        end else begin
          pc_stall = 1'b0;
        end
        if (state == S_RUN) begin
          if (mem_busy) begin
            state_nxt    = S_MEM_WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end else begin
            wait_cnt_nxt = '0;
          end
        end else if (!mem_busy) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT)) begin
          state_nxt = S_ERR;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end else begin
          wait_cnt_nxt = wait_cnt;
        end
      end
      S_ERR: begin
        pc_stall  = 1'b1;
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        mem_err   = 1'b1;
      end
      default: begin
        state_nxt = S_FLUSH;
      end
    endcase
    // Reset behaves like a flush immediately, even before the state register resets.
    if (rst) begin
      pc_stall  = 1'b1;
      if_stall  = 1'b0;
      if_clear  = 1'b1;
      id_stall  = 1'b0;
      id_clear  = 1'b1;
      ex_stall  = 1'b0;
      ex_clear  = 1'b1;
      mem_stall = 1'b0;
      mem_clear = 1'b1;
      mem_err   = 1'b0;
    end else begin
      mem_err = mem_err;
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  logic active, sel_load, sel_flush;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign active    = ((state == S_RUN) || (state == S_MEM_WAIT)) & ~rst;
  assign sel_load  = active & ~mem_busy & ~ex_branch & load_use;
  assign sel_flush = active & ~mem_busy & (ex_branch | (~load_use & id_jump));

  // Saturating event counters, frozen while flushing or locked out.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_stall <= '0;
      perf_mem_stall  <= '0;
      perf_flush      <= '0;
    end else begin
      if (sel_load && (perf_load_stall != CNT_MAX))
        perf_load_stall <= perf_load_stall + CNT_W'(1);
      if (active && mem_busy && (perf_mem_stall != CNT_MAX))
        perf_mem_stall <= perf_mem_stall + CNT_W'(1);
      if (sel_flush && (perf_flush != CNT_MAX))
        perf_flush <= perf_flush + CNT_W'(1);
    end
  end
`endif

endmodule
